uncache_axi_bridge: RTL
=======================

Name: uncache_axi_bridge

Overview:
- Sits directly downstream of the uncached-access tag stage in the data path.
- Consumes that stage's single-beat request (axi_e/axi_we/axi_addr/axi_wdata/axi_wsel) and runs one AXI4-Lite-style master transaction: AR/R for loads, AW+W/B for stores.
- Returns a one-cycle `refresh` completion pulse, plus read data and an error flag, to the tag stage.
- Handles one transaction at a time; nothing is outstanding in parallel.

Parameters:
- AXI_ADDR_W, 32: width of the AXI address buses; driven from req_addr[AXI_ADDR_W-1:0].
- TIMEOUT_CYCLES, 1024: watchdog limit, used only when UNCACHE_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_e  in  1  request valid (level, held by upstream until refresh)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  64  byte address
- req_wdata  in  64  store data
- req_wsel  in  8  store byte strobes
- refresh  out  1  one-cycle completion pulse
- rdata  out  64  load data; valid in the refresh cycle and held until the next completion
- resp_err  out  1  valid with refresh; 1 if the AXI response was not OKAY (or timed out)
- busy  out  1  high from acceptance through the refresh cycle
- araddr  out  AXI_ADDR_W  read address
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- r_data  in  64  AXI read data
- rresp  in  2  AXI read response
- rvalid  in  1  read data valid
- rready  out  1  read data ready
- awaddr  out  AXI_ADDR_W  write address
- awvalid  out  1  write address valid
- awready  in  1  write address ready
- wdata  out  64  write data
- wstrb  out  8  write strobes
- wvalid  out  1  write data valid
- wready  in  1  write data ready
- bresp  in  2  write response
- bvalid  in  1  write response valid
- bready  out  1  write response ready

Behaviour:
- Reset: all outputs are 0 (refresh, rdata, resp_err, busy, every valid/ready, addresses, wdata, wstrb); state = IDLE.
- Capture: in IDLE with req_e=1, latch req_we/addr/wdata/wsel into internal registers and set busy=1 the next cycle.
  - Load goes to state AR; store goes to state AW_W.
  - Address, data and strobe outputs are driven only from the latched copies; later changes on req_* are ignored.
- AR: arvalid=1 with araddr = latched addr[AXI_ADDR_W-1:0].
  - On arvalid&arready, drop arvalid and go to R.
- R: rready=1.
  - On rvalid, capture rdata = r_data and resp_err = (rresp != 2'b00).
  - Drop rready and go to DONE.
- AW_W: awvalid=1 and wvalid=1 rise in the same cycle, with wstrb = latched sel.
  - Each handshake completes independently; the corresponding valid drops the cycle after its own handshake.
  - Sticky flags aw_done and w_done record completion.
  - When both are done (including both in the same cycle), go to B.
- B: bready=1.
  - On bvalid, set resp_err = (bresp != 2'b00); rdata is unchanged.
  - Go to DONE.
- DONE: refresh=1 for exactly one cycle, then go to DROP.
  - busy stays 1 in DONE and falls in DROP.
- DROP: wait until req_e=0, then go to IDLE. This prevents re-issuing a request the upstream still holds after refresh.
  - If req_e is already 0 in the DONE cycle, DROP lasts one cycle.
- Latency:
  - Load with zero-wait slave: accept cycle 0, arvalid in cycle 1, R in cycle 2, refresh in cycle 3.
  - Store with zero-wait slave: awvalid/wvalid in cycle 1, B in cycle 2, refresh in cycle 3.
- Valid stability: a valid, once raised, is never dropped before its ready. Address and data are stable while the valid is high.
- Unexpected responses: rvalid/bvalid arriving in any state other than R/B is ignored; ready stays low in those states.
- Reset mid-transaction: all valids drop immediately and state returns to IDLE. The slave must tolerate the abandoned transaction.
- Illegal state encoding: recovers to IDLE with all valids low.

Optional Feature:
- Macro UNCACHE_TIMEOUT_EN.
- Defined:
  - A counter clears on acceptance and increments every cycle spent in AR, R, AW_W or B.
  - On reaching TIMEOUT_CYCLES, all valids/readies drop, resp_err=1, rdata=0, and the block goes to DONE (refresh pulses as normal).
- Not defined: no counter exists, and the block waits indefinitely for the slave.

Test Plan:
- Load: req_e=1, we=0, addr=0xA000_0048; slave arready=1 immediately, then rvalid with r_data=0x1122334455667788, rresp=0 -> araddr=0xA0000048, refresh in cycle 3, rdata=0x1122334455667788, resp_err=0.
- Store with skew: addr=0xA000_03F8, wdata=0xDEADBEEF, sel=0x0F; awready delayed 3 cycles, wready immediate -> wvalid drops after cycle 1, awvalid held until cycle 4, wstrb=0x0F, refresh after bvalid.
- Error: load with rresp=2'b10 -> refresh with resp_err=1; store with bresp=2'b11 -> resp_err=1.
- Held request: req_e held for 5 cycles after refresh -> exactly one AR issued; after req_e goes 0 then 1, a second AR is issued.
- Reset mid-flight: assert rst while in AW_W with awready=0 -> next cycle awvalid=wvalid=0, busy=0, state IDLE, no refresh.
- Timeout (UNCACHE_TIMEOUT_EN, TIMEOUT_CYCLES=16): arready stuck at 0 -> arvalid drops and refresh pulses with resp_err=1, rdata=0, 16 cycles after entering AR.

Source files
------------

// File: rtl/uncache_axi_bridge.sv
// uncache_axi_bridge
//   Converts the single-beat request from the uncached-access tag stage into one
//   AXI4-Lite-style master transaction (AR/R for loads, AW+W/B for stores) and
//   returns a one-cycle refresh pulse with read data and an error flag.
//   Only one transaction is in flight at a time.
//
//   Optional build macro: UNCACHE_TIMEOUT_EN
//     Defined   - a watchdog aborts a transaction after TIMEOUT_CYCLES cycles
//                 waiting on the slave; completes with resp_err=1, rdata=0.
//     Undefined - no watchdog; the block waits indefinitely for the slave.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_e/we/addr/wdata/wsel upstream request (level, held until refresh)
//   refresh                  one-cycle completion pulse
//   rdata, resp_err          load data / non-OKAY response flag
//   busy                     high from acceptance through the refresh cycle
//   ar*/r*/aw*/w*/b*         AXI master channels
module uncache_axi_bridge #(
    parameter int unsigned AXI_ADDR_W     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_e,
    input  logic                  req_we,
    input  logic [63:0]           req_addr,
    input  logic [63:0]           req_wdata,
    input  logic [7:0]            req_wsel,
    output logic                  refresh,
    output logic [63:0]           rdata,
    output logic                  resp_err,
    output logic                  busy,
    output logic [AXI_ADDR_W-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [63:0]           r_data,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [AXI_ADDR_W-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [63:0]           wdata,
    output logic [7:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW_W = 3'd3,
        S_B    = 3'd4,
        S_DONE = 3'd5,
        S_DROP = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  sel_q;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        accept;

    // Bits above AXI_ADDR_W are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_q;

    // Latched request; the direction itself is held by the state (AR vs AW_W).
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            sel_q   <= req_wsel;
        end
    end

`ifdef UNCACHE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             waiting;
    logic             timeout;

    assign waiting = (state_q == S_AR) || (state_q == S_R) ||
                     (state_q == S_AW_W) || (state_q == S_B);
    // Fires in the TIMEOUT_CYCLES-th waiting cycle so DONE follows immediately.
    assign timeout = waiting && (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (accept) begin
            tmo_d = '0;
        end else if (waiting) begin
            tmo_d = tmo_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_e) begin
                    accept    = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_we ? S_AW_W : S_AR;
                end
            end
            S_AR: begin
                if (arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (rvalid) begin
                    rdata_d = r_data;
                    err_d   = (rresp != 2'b00);
                    state_d = S_DONE;
                end
            end
            S_AW_W: begin
                if (awready) begin
                    aw_done_d = 1'b1;
                end
                if (wready) begin
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = S_B;
                end
            end
            S_B: begin
                if (bvalid) begin
                    err_d   = (bresp != 2'b00);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DROP;
            end
            S_DROP: begin
                // Upstream still holds req_e after refresh; wait for release.
                if (!req_e) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef UNCACHE_TIMEOUT_EN
        if (timeout) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // All handshake outputs are decoded from state, so any exit (normal,
    // timeout, reset or illegal encoding) drops them together.
    assign arvalid  = (state_q == S_AR);
    assign rready   = (state_q == S_R);
    assign awvalid  = (state_q == S_AW_W) && !aw_done_q;
    assign wvalid   = (state_q == S_AW_W) && !w_done_q;
    assign bready   = (state_q == S_B);
    assign refresh  = (state_q == S_DONE);
    assign busy     = (state_q == S_AR) || (state_q == S_R) || (state_q == S_AW_W) ||
                      (state_q == S_B)  || (state_q == S_DONE);
    assign araddr   = addr_q[AXI_ADDR_W-1:0];
    assign awaddr   = addr_q[AXI_ADDR_W-1:0];
    assign wdata    = wdata_q;
    assign wstrb    = sel_q;
    assign rdata    = rdata_q;
    assign resp_err = err_q;

endmodule
